// File: rtl/sr_pkg.sv
// Shared types and the per-channel SR next-state function for the SR register bank.
package sr_pkg;

    // Resolution applied when set and reset are both requested
    typedef enum logic [1:0] {
        SR_HOLD    = 2'd0,
        SR_SET_DOM = 2'd1,
        SR_RST_DOM = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    // Next state of one enabled SR channel; never produces X for known inputs
    function automatic logic sr_next(input sr_mode_e mode, input logic q,
                                     input logic s, input logic r);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00: nxt = q;
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                case (mode)
                    SR_HOLD:    nxt = q;
                    SR_SET_DOM: nxt = 1'b1;
                    SR_RST_DOM: nxt = 1'b0;
                    SR_TOGGLE:  nxt = ~q;
                    default:    nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked SR channel: state flop, edge-pulse flops and sticky conflict flag.
module sr_cell
    import sr_pkg::*;
#(
    parameter int   CONFLICT_MODE = 0,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic conflict_clr,
    output logic q,
    output logic qbar,
    output logic rise,
    output logic fall,
    output logic conflict,
    output logic conflict_sticky
);

    localparam sr_mode_e MODE = sr_mode_e'(CONFLICT_MODE[1:0]);

    logic r_q;
    logic r_rise;
    logic r_fall;
    logic r_sticky;
    logic w_q_next;
    logic w_conflict;

    // Conflicts only count while the bank is enabled, in every mode
    assign w_conflict = en & s & r;
    assign w_q_next   = en ? sr_next(MODE, r_q, s, r) : r_q;

    // State, edge pulses and sticky flag; reset load itself yields no pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q      <= RESET_VALUE;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_rise   <= w_q_next & ~r_q;
            r_fall   <= ~w_q_next & r_q;
            // A new conflict beats a simultaneous write-1-to-clear
            r_sticky <= w_conflict | (r_sticky & ~conflict_clr);
        end
    end

    assign q               = r_q;
    assign qbar            = ~r_q;
    assign rise            = r_rise;
    assign fall            = r_fall;
    assign conflict        = w_conflict;
    assign conflict_sticky = r_sticky;

endmodule

// File: rtl/sr_register_bank.sv
// Bank of WIDTH clocked SR flip-flops with shared enable/reset and a
// saturating count of enabled cycles in which any channel saw S=R=1.
module sr_register_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict_sticky,
    input  logic [WIDTH-1:0] conflict_clr,
    output logic [CNT_W-1:0] conflict_cnt,
    input  logic             cnt_clr
);

    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
        $error("sr_register_bank: CONFLICT_MODE must be 0..3");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sr_register_bank: WIDTH must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] w_conflict;
    logic             w_any_conflict;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .CONFLICT_MODE (CONFLICT_MODE),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_cell (
            .clk             (clk),
            .rst_n           (rst_n),
            .en              (en),
            .s               (s[i]),
            .r               (r[i]),
            .conflict_clr    (conflict_clr[i]),
            .q               (q[i]),
            .qbar            (qbar[i]),
            .rise            (rise[i]),
            .fall            (fall[i]),
            .conflict        (w_conflict[i]),
            .conflict_sticky (conflict_sticky[i])
        );
    end

    // One count per cycle regardless of how many channels conflict
    assign w_any_conflict = |w_conflict;

    // Conflict counter: clear wins over increment, reset wins over both
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_any_conflict) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_register_bank.sv
// Scoreboard bench for sr_register_bank: four instances (one per conflict
// mode) share stimulus; hand-computed expectations are queued per cycle and
// a negedge monitor pops and compares them.
module tb_sr_register_bank;

    localparam int         W  = 4;
    localparam int         CW = 3;
    localparam logic [3:0] RV = 4'b1010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  s;
    logic [W-1:0]  r;
    logic [W-1:0]  conflict_clr;
    logic          cnt_clr;

    logic [W-1:0]  q_m    [4];
    logic [W-1:0]  qb_m   [4];
    logic [W-1:0]  rise_m [4];
    logic [W-1:0]  fall_m [4];
    logic [W-1:0]  st_m   [4];
    logic [CW-1:0] cnt_m  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_register_bank #(
            .WIDTH         (W),
            .CONFLICT_MODE (g),
            .RESET_VALUE   (RV),
            .CNT_W         (CW)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .en              (en),
            .s               (s),
            .r               (r),
            .q               (q_m[g]),
            .qbar            (qb_m[g]),
            .rise            (rise_m[g]),
            .fall            (fall_m[g]),
            .conflict_sticky (st_m[g]),
            .conflict_clr    (conflict_clr),
            .conflict_cnt    (cnt_m[g]),
            .cnt_clr         (cnt_clr)
        );
    end

    typedef struct {
        string           name;
        int              cyc;
        logic [3:0][3:0] q;
        logic [3:0][3:0] rise;
        logic [3:0][3:0] fall;
        logic [3:0]      st;
        logic [2:0]      cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", nm, act, req);
        end
    endtask

    // Monitor: compare every queued expectation due at this cycle
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check($sformatf("%s_due_cycle", e.name), 8'(cyc), 8'(e.cyc));
            for (int m = 0; m < 4; m++) begin
                check($sformatf("%s_m%0d_q", e.name, m),    {4'b0, q_m[m]},    {4'b0, e.q[m]});
                check($sformatf("%s_m%0d_qbar", e.name, m), {4'b0, qb_m[m]},   {4'b0, ~e.q[m]});
                check($sformatf("%s_m%0d_rise", e.name, m), {4'b0, rise_m[m]}, {4'b0, e.rise[m]});
                check($sformatf("%s_m%0d_fall", e.name, m), {4'b0, fall_m[m]}, {4'b0, e.fall[m]});
                check($sformatf("%s_m%0d_sticky", e.name, m), {4'b0, st_m[m]}, {4'b0, e.st});
                check($sformatf("%s_m%0d_cnt", e.name, m),  {5'b0, cnt_m[m]},  {5'b0, e.cnt});
            end
        end
    end

    task automatic drv(input logic rn, input logic e, input logic [3:0] ss,
                       input logic [3:0] rr, input logic [3:0] cc, input logic ctc);
        rst_n        = rn;
        en           = e;
        s            = ss;
        r            = rr;
        conflict_clr = cc;
        cnt_clr      = ctc;
    endtask

    // Expectation after the next rising edge, per mode (index 0 = mode 0)
    task automatic expm(input string nm, input logic [3:0][3:0] eq,
                        input logic [3:0][3:0] er, input logic [3:0][3:0] ef,
                        input logic [3:0] es, input logic [2:0] ec);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + 1;
        e.q    = eq;
        e.rise = er;
        e.fall = ef;
        e.st   = es;
        e.cnt  = ec;
        sb.push_back(e);
    endtask

    // Same expectation for all four modes
    task automatic expa(input string nm, input logic [3:0] eq, input logic [3:0] er,
                        input logic [3:0] ef, input logic [3:0] es, input logic [2:0] ec);
        expm(nm, {4{eq}}, {4{er}}, {4{ef}}, es, ec);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q3, r3, f3, r1, f2;
        logic [2:0] c;

        // Reset held two edges, then released with s=r=0
        drv(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expa("reset1", RV, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();
        expa("reset2", RV, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();
        drv(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expa("release", RV, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();

        // Basic set then clear of channel 0, then disabled writes
        drv(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        expa("set0", 4'b1011, 4'b0001, 4'b0000, 4'b0000, 3'd0); tick();
        drv(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        expa("clr0", 4'b1010, 4'b0000, 4'b0001, 4'b0000, 3'd0); tick();
        drv(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        expa("en0_set", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();
        drv(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        expa("en0_conf", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();

        // Load 0101, then one S=R=1111 cycle resolved per mode
        drv(1'b1, 1'b1, 4'b0101, 4'b1010, 4'b0000, 1'b0);
        expa("prep", 4'b0101, 4'b0101, 4'b1010, 4'b0000, 3'd0); tick();
        drv(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        expm("modes", {4'b1010, 4'b0000, 4'b1111, 4'b0101},
                      {4'b1010, 4'b0000, 4'b1010, 4'b0000},
                      {4'b0101, 4'b0101, 4'b0000, 4'b0000}, 4'b1111, 3'd1); tick();
        drv(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1);
        expa("resync1", RV, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();

        // Sticky flag on channel 2: set, set+clear together, clear alone
        drv(1'b1, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0);
        expm("stk_set", {4'b1110, 4'b1010, 4'b1110, 4'b1010},
                        {4'b0100, 4'b0000, 4'b0100, 4'b0000},
                        {4'b0000, 4'b0000, 4'b0000, 4'b0000}, 4'b0100, 3'd1); tick();
        drv(1'b1, 1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b0);
        expm("stk_setclr", {4'b1010, 4'b1010, 4'b1110, 4'b1010},
                           {4'b0000, 4'b0000, 4'b0000, 4'b0000},
                           {4'b0100, 4'b0000, 4'b0000, 4'b0000}, 4'b0100, 3'd2); tick();
        drv(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0);
        expm("stk_clr", {4'b1010, 4'b1010, 4'b1110, 4'b1010},
                        {4'b0000, 4'b0000, 4'b0000, 4'b0000},
                        {4'b0000, 4'b0000, 4'b0000, 4'b0000}, 4'b0000, 3'd2); tick();
        drv(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expa("resync2", RV, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();

        // Counter saturation: 9 cycles of conflicts on channels 0 and 1
        for (int k = 1; k <= 9; k++) begin
            drv(1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b0);
            q3 = (k % 2 == 1) ? 4'b1001 : 4'b1010;
            r3 = (k % 2 == 1) ? 4'b0001 : 4'b0010;
            f3 = (k % 2 == 1) ? 4'b0010 : 4'b0001;
            r1 = (k == 1) ? 4'b0001 : 4'b0000;
            f2 = (k == 1) ? 4'b0010 : 4'b0000;
            c  = (k < 7) ? 3'(k) : 3'd7;
            expm($sformatf("cnt_k%0d", k), {q3, 4'b1000, 4'b1011, 4'b1010},
                 {r3, 4'b0000, r1, 4'b0000}, {f3, f2, 4'b0000, 4'b0000}, 4'b0011, c);
            tick();
        end

        // cnt_clr wins over a simultaneous conflict
        drv(1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b1);
        expm("cnt_clr", {4'b1010, 4'b1000, 4'b1011, 4'b1010},
                        {4'b0010, 4'b0000, 4'b0000, 4'b0000},
                        {4'b0001, 4'b0000, 4'b0000, 4'b0000}, 4'b0011, 3'd0); tick();
        drv(1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b0);
        expm("cnt_after", {4'b1001, 4'b1000, 4'b1011, 4'b1010},
                          {4'b0001, 4'b0000, 4'b0000, 4'b0000},
                          {4'b0010, 4'b0000, 4'b0000, 4'b0000}, 4'b0011, 3'd1); tick();

        // Reset in the middle of toggling, then resume from RESET_VALUE
        drv(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        expa("mid_reset", RV, 4'b0000, 4'b0000, 4'b0000, 3'd0); tick();
        drv(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        expm("resume", {4'b0101, 4'b0000, 4'b1111, 4'b1010},
                       {4'b0101, 4'b0000, 4'b0101, 4'b0000},
                       {4'b1010, 4'b1010, 4'b0000, 4'b0000}, 4'b1111, 3'd1); tick();
        drv(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Drain: every queued expectation must have been consumed
        repeat (3) tick();
        check("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
